// File: rtl/lf_field_sched.sv
`default_nettype none
// ============================================================================
// Module      : lf_field_sched
// Description : LF reader field scheduler. Runs queued {gap, hold} commands
//               as timed field-off / field-on intervals counted in carrier
//               periods. Drives the carrier divisor and lf_field, and masks
//               ADC samples during gaps and the antenna settle time after them.
// Revision    : 1.0 - initial release
// ============================================================================
module lf_field_sched #(
    parameter int CNT_W           = 16,
    parameter int SETTLE_TICKS    = 8,
    parameter int DEFAULT_DIVISOR = 95
) (
    input  logic             pck0,
    input  logic             rst,
    input  logic [7:0]       cfg_divisor,
    input  logic             cfg_idle_field,
    input  logic             abort,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_gap,
    input  logic [CNT_W-1:0] cmd_hold,
    output logic [7:0]       divisor,
    output logic             lf_field,
    output logic             sample_en,
    output logic             busy,
    output logic             seq_done
);

    // Settle counter must hold SETTLE_TICKS; keep at least one bit when it is 0.
    localparam int c_SETTLE_W = (SETTLE_TICKS < 1) ? 1 : $clog2(SETTLE_TICKS + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(SETTLE_TICKS);
    localparam logic [7:0]            c_DIV_INIT    = 8'(DEFAULT_DIVISOR);
    localparam logic [CNT_W-1:0]      c_ONE         = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_W-1:0]      r_dcnt;
    logic [CNT_W-1:0]      r_cur_hold;
    logic [c_SETTLE_W-1:0] r_settle;
    logic [8:0]            r_tcnt;

    logic [CNT_W-1:0]      r_gap_mem  [0:1];
    logic [CNT_W-1:0]      r_hold_mem [0:1];
    logic                  r_rd;
    logic [1:0]            r_count;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_done;
    logic                  w_load_div;
    logic                  w_wr_idx;
    logic [CNT_W-1:0]      w_head_gap;
    logic [CNT_W-1:0]      w_head_hold;
    logic [CNT_W-1:0]      w_hold_eff;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_dcnt_nxt;
    logic [CNT_W-1:0]      w_cur_hold_nxt;
    logic [c_SETTLE_W-1:0] w_settle_nxt;
    logic [1:0]            w_count_nxt;

    // Tick fires on the last count of a 2*(divisor+1) period, i.e. 2*divisor+1.
    assign w_tick = (r_tcnt == {divisor, 1'b1});

    assign w_empty     = (r_count == 2'd0);
    assign w_full      = r_count[1];
    assign cmd_ready   = ~w_full;
    assign w_push      = cmd_valid & ~w_full & ~abort;
    assign w_wr_idx    = r_rd ^ r_count[0];
    assign w_head_gap  = r_gap_mem[r_rd];
    assign w_head_hold = r_hold_mem[r_rd];
    assign w_hold_eff  = (w_head_hold == '0) ? c_ONE : w_head_hold;
    assign w_count_nxt = abort ? 2'd0
                               : (r_count + {1'b0, w_push} - {1'b0, w_pop});

    // Carrier period counter; the divisor only changes at a wrap, so a
    // period is never cut short.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 9'd1;
        end
    end

    // Sequencer next-state: abort wins over tick; pops only happen on ticks.
    always_comb begin
        w_state_nxt    = r_state;
        w_dcnt_nxt     = r_dcnt;
        w_cur_hold_nxt = r_cur_hold;
        w_settle_nxt   = r_settle;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        w_load_div     = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            if (r_state == ST_GAP) begin
                w_settle_nxt = c_SETTLE_INIT;
            end
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_load_div = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_dcnt == c_ONE) begin
                        w_state_nxt = ST_HOLD;
                        w_dcnt_nxt  = r_cur_hold;
                    end else begin
                        w_dcnt_nxt = r_dcnt - c_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_dcnt == c_ONE) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done      = 1'b1;
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt - c_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_pop) begin
                w_cur_hold_nxt = w_hold_eff;
                if (w_head_gap != '0) begin
                    w_state_nxt = ST_GAP;
                    w_dcnt_nxt  = w_head_gap;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_dcnt_nxt  = w_hold_eff;
                end
            end

            // Every gap entry restarts the settle time; it only runs down
            // while the field is not in a gap.
            if (w_pop && (w_head_gap != '0)) begin
                w_settle_nxt = c_SETTLE_INIT;
            end else if ((r_state != ST_GAP) && (r_settle != '0)) begin
                w_settle_nxt = r_settle - c_SETTLE_W'(1);
            end
        end
    end

    // Sequencer state and registered outputs, all derived from next state so
    // they change on the same edge as the state.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dcnt     <= '0;
            r_cur_hold <= c_ONE;
            r_settle   <= c_SETTLE_INIT;
            divisor    <= c_DIV_INIT;
            lf_field   <= 1'b0;
            sample_en  <= 1'b0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_cur_hold <= w_cur_hold_nxt;
            r_settle   <= w_settle_nxt;
            if (w_load_div) begin
                divisor <= cfg_divisor;
            end
            lf_field   <= (w_state_nxt == ST_HOLD) ? 1'b1 :
                          (w_state_nxt == ST_GAP)  ? 1'b0 : cfg_idle_field;
            sample_en  <= (w_state_nxt != ST_GAP) && (w_settle_nxt == '0);
            busy       <= (w_state_nxt != ST_IDLE) || (w_count_nxt != 2'd0);
            seq_done   <= w_done;
        end
    end

    // Two-entry command FIFO; abort flushes it and discards a same-cycle push.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            r_rd          <= 1'b0;
            r_count       <= 2'd0;
            r_gap_mem[0]  <= '0;
            r_gap_mem[1]  <= '0;
            r_hold_mem[0] <= '0;
            r_hold_mem[1] <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_pop && !abort) begin
                r_rd <= ~r_rd;
            end
            if (w_push) begin
                r_gap_mem[w_wr_idx]  <= cmd_gap;
                r_hold_mem[w_wr_idx] <= cmd_hold;
            end
        end
    end

endmodule
`default_nettype wire
